// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   o_dmem_req   : access request, held until ack or abort
//   o_dmem_we    : 1 = store, 0 = load
//   o_dmem_addr  : word-aligned address
//   o_dmem_wdata : store data
//   i_dmem_ack   : access completes this cycle
//   i_dmem_rdata : load data, valid with ack
// master = MEM stage side, slave = memory side.
interface mem_stage_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM pipeline register, word load/store over a req/ack
// data-memory bus with timeout, upstream stall, registered MEM/WB bundle.
// Ports:
//   clk, nrst            : clock, synchronous active-high reset
//   i_MEM_* / i_WB_*     : bundle from EX (captured when o_stall = 0)
//   o_stall              : upstream must hold its bundle this cycle
//   dmem                 : data-memory bus (master side)
//   o_WB_*               : registered bundle to writeback
//   o_MEM_exc(_code)     : one-cycle exception pulse, 01 ovf / 10 misaligned / 11 timeout
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_MEM_valid,
    input  logic [31:0] i_MEM_data_ALUOut,
    input  logic        i_MEM_data_Overflow,
    input  logic [31:0] i_MEM_data_RTData,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic [4:0]  i_WB_data_RegAddrW,
    input  logic        i_WB_ctrl_Mem2Reg,
    input  logic        i_WB_ctrl_RegWrite,
    output logic        o_stall,
    mem_stage_if.master dmem,
    output logic        o_WB_valid,
    output logic [4:0]  o_WB_data_RegAddrW,
    output logic [31:0] o_WB_data_WData,
    output logic        o_WB_ctrl_RegWrite,
    output logic        o_MEM_exc,
    output logic [1:0]  o_MEM_exc_code
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {RUN, WAIT} state_t;

    // EX/MEM register
    logic        ex_valid, ex_ovf, ex_mem_read, ex_mem_write, ex_mem2reg, ex_reg_write;
    logic [31:0] ex_alu_out, ex_rt_data;
    logic [4:0]  ex_reg_addr;

    always_ff @(posedge clk) begin
        if (nrst) begin
            ex_valid     <= 1'b0;
            ex_ovf       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_mem2reg   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_alu_out   <= '0;
            ex_rt_data   <= '0;
            ex_reg_addr  <= '0;
        end else if (!o_stall) begin
            ex_valid     <= i_MEM_valid;
            ex_ovf       <= i_MEM_data_Overflow;
            ex_mem_read  <= i_MEM_ctrl_MemRead;
            ex_mem_write <= i_MEM_ctrl_MemWrite;
            ex_mem2reg   <= i_WB_ctrl_Mem2Reg;
            ex_reg_write <= i_WB_ctrl_RegWrite;
            ex_alu_out   <= i_MEM_data_ALUOut;
            ex_rt_data   <= i_MEM_data_RTData;
            ex_reg_addr  <= i_WB_data_RegAddrW;
        end
    end

    // Classification of the held instruction; overflow takes priority.
    logic is_access, is_ovf, is_misal, is_mem, is_alu, is_exc;

    assign is_access = ex_mem_read | ex_mem_write;
    assign is_ovf    = ex_valid & ex_ovf;
    assign is_misal  = ex_valid & ~ex_ovf & is_access & (ex_alu_out[1:0] != 2'b00);
    assign is_mem    = ex_valid & ~ex_ovf & is_access & (ex_alu_out[1:0] == 2'b00);
    assign is_alu    = ex_valid & ~ex_ovf & ~is_access;
    assign is_exc    = is_ovf | is_misal;

    // Memory handshake
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          req, ack, abort;

    assign req   = is_mem;
    assign ack   = req & dmem.i_dmem_ack;       // ack without req is ignored
    // cnt holds the number of earlier unacked req cycles, so cnt == TIMEOUT-1
    // marks the TIMEOUT-th req cycle. Ack in that same cycle wins.
    assign abort = req & ~ack & (cnt == CW'(TIMEOUT - 1));

    assign o_stall           = req & ~ack & ~abort;
    assign dmem.o_dmem_req   = req;
    assign dmem.o_dmem_we    = req & ex_mem_write;
    assign dmem.o_dmem_addr  = req ? ex_alu_out : '0;
    assign dmem.o_dmem_wdata = req ? ex_rt_data : '0;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                cnt_nxt = '0;
                if (o_stall) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT: begin
                if (ack || abort || !req) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // MEM/WB register: a bubble unless the held instruction retires this edge.
    always_ff @(posedge clk) begin
        if (nrst) begin
            o_WB_valid         <= 1'b0;
            o_WB_data_RegAddrW <= '0;
            o_WB_data_WData    <= '0;
            o_WB_ctrl_RegWrite <= 1'b0;
            o_MEM_exc          <= 1'b0;
            o_MEM_exc_code     <= 2'b00;
        end else begin
            o_WB_valid         <= 1'b0;
            o_WB_data_RegAddrW <= '0;
            o_WB_data_WData    <= '0;
            o_WB_ctrl_RegWrite <= 1'b0;
            o_MEM_exc          <= 1'b0;
            o_MEM_exc_code     <= 2'b00;
            if (is_alu) begin
                o_WB_valid         <= 1'b1;
                o_WB_data_RegAddrW <= ex_reg_addr;
                o_WB_data_WData    <= ex_alu_out;
                o_WB_ctrl_RegWrite <= ex_reg_write;
            end else if (is_exc) begin
                o_WB_valid         <= 1'b1;
                o_WB_data_RegAddrW <= ex_reg_addr;
                o_WB_data_WData    <= ex_alu_out;
                o_MEM_exc          <= 1'b1;
                o_MEM_exc_code     <= is_ovf ? 2'b01 : 2'b10;
            end else if (ack) begin
                o_WB_valid         <= 1'b1;
                o_WB_data_RegAddrW <= ex_reg_addr;
                o_WB_data_WData    <= ex_mem2reg ? dmem.i_dmem_rdata : ex_alu_out;
                o_WB_ctrl_RegWrite <= ex_reg_write & ~ex_mem_write;
            end else if (abort) begin
                o_WB_valid         <= 1'b1;
                o_WB_data_RegAddrW <= ex_reg_addr;
                o_WB_data_WData    <= ex_alu_out;
                o_MEM_exc          <= 1'b1;
                o_MEM_exc_code     <= 2'b11;
            end
        end
    end
endmodule
